led_pattern_sequencer: RTL and testbench

- Controller that drives an LED bank with a selectable shift/blink pattern at a slow, prescaled step rate.
- Sequences the "LEDs light left to right" shift-register behaviour: fill, drain, repeat.
- Runs a fixed loop count or runs until stopped.
- Sits between board buttons/switches (start, stop, mode) and the LED pins.

---
 rtl/led_pattern_sequencer.sv | 127 ++++++++++++
 tb/tb_led_pattern_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// LED bank sequencer: prescaled shift/blink patterns, fixed loop count or free-running.
// q updates DIV clocks after start acceptance, then every DIV clocks; stop always wins.
module led_pattern_sequencer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [3:0]       loops,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = $clog2(2 * WIDTH);
  localparam logic [PW-1:0]    PRE_LAST  = PW'(DIV - 1);
  localparam logic [SW-1:0]    STEP_LAST = SW'(2 * WIDTH - 1);
  localparam logic [SW-1:0]    STEP_HALF = SW'(WIDTH);
  localparam logic [WIDTH-1:0] ALT_EVEN  = {(WIDTH / 2){2'b10}};
  localparam logic [WIDTH-1:0] ALT_ODD   = {(WIDTH / 2){2'b01}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [3:0]       loops_q, loops_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [SW-1:0]    step_q, step_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             done_q, done_d;

  logic             tick;
  logic             fill;
  logic             even;
  logic [WIDTH-1:0] pat;

  assign tick = (presc_q == PRE_LAST);
  assign fill = (step_q < STEP_HALF);
  assign even = ~step_q[0];

  always_comb begin
    pat = '0;
    case (mode_q)
      2'd0:    pat = {fill, q_q[WIDTH-1:1]};
      2'd1:    pat = {q_q[WIDTH-2:0], fill};
      2'd2:    pat = even ? ALT_EVEN : ALT_ODD;
      default: pat = even ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    loops_d = loops_q;
    cnt_d   = cnt_q;
    presc_d = presc_q;
    step_d  = step_q;
    q_d     = q_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          mode_d  = mode;
          loops_d = loops;
          cnt_d   = '0;
          presc_d = '0;
          step_d  = '0;
          q_d     = '0;
        end
      end
      default: begin
        if (stop) begin
          state_d = IDLE;
          q_d     = '0;
        end else begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            q_d    = pat;
            step_d = (step_q == STEP_LAST) ? '0 : step_q + SW'(1);
            if (step_q == STEP_LAST) begin
              cnt_d = cnt_q + 4'd1;
              // loops_q==0 never matches here, so the count just wraps
              if (loops_q != 4'd0 && cnt_q == loops_q - 4'd1) begin
                state_d = IDLE;
                q_d     = '0;
                done_d  = 1'b1;
              end
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mode_q  <= '0;
      loops_q <= '0;
      cnt_q   <= '0;
      presc_q <= '0;
      step_q  <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      loops_q <= loops_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      step_q  <= step_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with WIDTH=8, DIV=4.
module tb_led_pattern_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic [3:0] loops;
  logic [7:0] q;
  logic       busy;
  logic       done;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] exp0 [0:15] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
                              8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};
  logic [7:0] exp1 [0:15] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                              8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};

  led_pattern_sequencer #(.WIDTH(8), .DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .stop  (stop),
    .mode  (mode),
    .loops (loops),
    .q     (q),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench 1 ns after the accept edge.
  task automatic do_start(input logic [1:0] m, input logic [3:0] l);
    mode  = m;
    loops = l;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b1; stop = 1'b0; mode = 2'd0; loops = 4'd1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      n_total++;
      if ({q, busy, done} !== 10'h000)
        $display("FAIL reset_hold: q=%h busy=%b done=%b, need 00/0/0", q, busy, done);
      else n_pass++;
    end
    start = 1'b0;
    reset = 1'b1;
    cyc(8);
    n_total++;
    if ({q, busy, done} !== 10'h000)
      $display("FAIL reset_release_idle: q=%h busy=%b done=%b, need 00/0/0", q, busy, done);
    else n_pass++;
  endtask

  task automatic test_mode0;
    do_start(2'd0, 4'd1);
    n_total++;
    if (busy !== 1'b1 || q !== 8'h00)
      $display("FAIL m0_accept: busy=%b q=%h, need 1/00", busy, q);
    else n_pass++;
    cyc(3);
    n_total++;
    if (q !== 8'h00)
      $display("FAIL m0_latency: q=%h after 3 clocks, need 00", q);
    else n_pass++;
    cyc(1);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) cyc(4);
      n_total++;
      if (q !== exp0[i] || done !== (i == 15) || busy !== (i != 15))
        $display("FAIL m0_tick%0d: q=%h done=%b busy=%b, need %h/%b/%b",
                 i, q, done, busy, exp0[i], (i == 15), (i != 15));
      else n_pass++;
    end
    cyc(1);
    n_total++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL m0_done_width: done=%b busy=%b, need 0/0", done, busy);
    else n_pass++;
  endtask

  task automatic test_mode1_back_to_back;
    do_start(2'd1, 4'd2);
    for (int i = 0; i < 32; i++) begin
      cyc(4);
      n_total++;
      if (q !== exp1[i % 16] || done !== (i == 31) || busy !== (i != 31))
        $display("FAIL m1_tick%0d: q=%h done=%b busy=%b, need %h/%b/%b",
                 i, q, done, busy, exp1[i % 16], (i == 31), (i != 31));
      else n_pass++;
    end
    do_start(2'd3, 4'd0);
    n_total++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL restart_on_done: busy=%b done=%b, need 1/0", busy, done);
    else n_pass++;
    cyc(4);
    n_total++;
    if (q !== 8'hFF)
      $display("FAIL restart_first_tick: q=%h, need FF", q);
    else n_pass++;
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    n_total++;
    if (busy !== 1'b0 || q !== 8'h00)
      $display("FAIL restart_stop: busy=%b q=%h, need 0/00", busy, q);
    else n_pass++;
  endtask

  task automatic test_forever(input logic [1:0] m, input int nticks,
                              input logic [7:0] ev, input logic [7:0] od);
    logic [7:0] e;
    do_start(m, 4'd0);
    for (int i = 0; i < nticks; i++) begin
      cyc(4);
      e = (i % 2 == 0) ? ev : od;
      n_total++;
      if (q !== e || done !== 1'b0 || busy !== 1'b1)
        $display("FAIL fv_m%0d_tick%0d: q=%h done=%b busy=%b, need %h/0/1",
                 m, i, q, done, busy, e);
      else n_pass++;
    end
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    n_total++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL fv_m%0d_stop: q=%h busy=%b done=%b, need 00/0/0", m, q, busy, done);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      n_total++;
      if (done !== 1'b0 || busy !== 1'b0)
        $display("FAIL fv_m%0d_after_stop: done=%b busy=%b, need 0/0", m, done, busy);
      else n_pass++;
    end
  endtask

  task automatic test_contention;
    mode = 2'd0; loops = 4'd1; start = 1'b1; stop = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b0;
    n_total++;
    if (busy !== 1'b0 || q !== 8'h00)
      $display("FAIL start_stop_idle: busy=%b q=%h, need 0/00", busy, q);
    else n_pass++;
    cyc(5);
    n_total++;
    if (busy !== 1'b0)
      $display("FAIL start_stop_idle_later: busy=%b, need 0", busy);
    else n_pass++;

    // Re-start plus mode/loops changes partway through must not disturb the run.
    do_start(2'd0, 4'd1);
    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < 4; c++) begin
        cyc(1);
        if (i == 2 && c == 0) begin
          start = 1'b1; mode = 2'd3; loops = 4'd5;
        end
        if (i == 2 && c == 1) start = 1'b0;
      end
      n_total++;
      if (q !== exp0[i] || done !== (i == 15))
        $display("FAIL midrun_tick%0d: q=%h done=%b, need %h/%b", i, q, done, exp0[i], (i == 15));
      else n_pass++;
    end

    do_start(2'd0, 4'd1);
    cyc(4 * 15);
    n_total++;
    if (q !== 8'h01)
      $display("FAIL stop_final_pre: q=%h, need 01", q);
    else n_pass++;
    cyc(3);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    n_total++;
    if (q !== 8'h00 || done !== 1'b0 || busy !== 1'b0)
      $display("FAIL stop_final: q=%h done=%b busy=%b, need 00/0/0", q, done, busy);
    else n_pass++;
    cyc(1);
    n_total++;
    if (done !== 1'b0)
      $display("FAIL stop_final_later: done=%b, need 0", done);
    else n_pass++;
  endtask

  task automatic test_reset_midrun;
    do_start(2'd0, 4'd0);
    cyc(16);
    n_total++;
    if (q !== 8'hF0)
      $display("FAIL rst_mid_pre: q=%h, need F0", q);
    else n_pass++;
    #2;
    reset = 1'b0;
    #1;
    n_total++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL rst_mid_async: q=%h busy=%b done=%b, need 00/0/0", q, busy, done);
    else n_pass++;
    #1;
    reset = 1'b1;
    cyc(2);
    n_total++;
    if (busy !== 1'b0 || q !== 8'h00)
      $display("FAIL rst_mid_idle: busy=%b q=%h, need 0/00", busy, q);
    else n_pass++;
    do_start(2'd0, 4'd1);
    cyc(4);
    n_total++;
    if (q !== 8'h80 || busy !== 1'b1)
      $display("FAIL rst_mid_restart: q=%h busy=%b, need 80/1", q, busy);
    else n_pass++;
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode1_back_to_back();
    test_forever(2'd2, 40, 8'hAA, 8'h55);
    test_forever(2'd3, 10, 8'hFF, 8'h00);
    test_contention();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
